// File: rtl/rr_sched_pkg.sv
// Shared types and the rotating-priority pick for the 16-way grant scheduler.
// The scan starts at the rotation pointer and wraps modulo 16.
package rr_sched_pkg;

  localparam int NREQ = 16;
  localparam int IDXW = 4;

  typedef logic [NREQ-1:0] req_vec_t;
  typedef logic [IDXW-1:0] idx_t;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  typedef struct packed {
    logic found;
    idx_t idx;
  } pick_t;

  // Walk offsets high to low so the lowest offset from ptr wins last.
  function automatic pick_t rr_pick(
    input req_vec_t req,
    input idx_t     ptr
  );
    pick_t p;
    idx_t  c;
    p = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      c = ptr + idx_t'(i);
      if (req[c]) begin
        p.found = 1'b1;
        p.idx   = c;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_grant_scheduler_dec4to16.sv
// 4-to-16 one-hot decoder; all outputs low when disabled.
// Used to turn the registered grant index into the grant bus.
module dec4to16
  import rr_sched_pkg::*;
(
  input  logic     enable,
  input  idx_t     in,
  output req_vec_t sel
);

  always_comb begin
    sel = '0;
    if (enable) sel[in] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler for 16 requesters with hold-timeout rotation.
// Grant index/valid are registered; the one-hot bus is a pure decode.
module rr_grant_scheduler
  import rr_sched_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     arb_en,
  input  req_vec_t req,
  input  logic     done,
  output logic     grant_valid,
  output idx_t     grant_idx,
  output req_vec_t grant,
  output logic     timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e     state_q;
  idx_t       ptr_q;
  idx_t       idx_q;
  logic       valid_q;
  logic       tmo_q;
  logic [7:0] hold_q;
  logic [7:0] hold_d;

  pick_t    pick;
  req_vec_t grant_sel;
  logic     owner_req;
  logic     others;
  logic     tmo;
  logic     rel;

  dec4to16 u_dec (
    .enable (valid_q),
    .in     (idx_q),
    .sel    (grant_sel)
  );

  always_comb begin
    pick      = rr_pick(req, ptr_q);
    owner_req = req[idx_q];
    others    = |(req & ~grant_sel);
    tmo       = (hold_q == HOLD_LAST) & others;
    rel       = done | ~owner_req | tmo;
    hold_d    = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      tmo_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (arb_en && pick.found) begin
            state_q <= GRANT;
            idx_q   <= pick.idx;
            valid_q <= 1'b1;
            hold_q  <= '0;
            ptr_q   <= pick.idx + idx_t'(1);
          end
        end
        GRANT: begin
          if (rel) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            // A done in the same cycle wins: plain release, no pulse.
            tmo_q   <= tmo & ~done & owner_req;
          end else if (hold_q == HOLD_LAST) begin
            hold_q <= '0;
          end else begin
            hold_q <= hold_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;
  assign grant       = grant_sel;
  assign timeout     = tmo_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler with hand-computed expectations.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_rr_grant_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        arb_en;
  logic [15:0] req;
  logic        done;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic [15:0] grant;
  logic        timeout;

  int checks = 0;
  int failures = 0;

  rr_grant_scheduler #(.MAX_HOLD(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .arb_en      (arb_en),
    .req         (req),
    .done        (done),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant       (grant),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {timeout, grant_valid, grant_idx, grant}
  function automatic logic [31:0] st(input logic t, input logic v,
                                     input logic [3:0] i,
                                     input logic [15:0] g);
    return {10'd0, t, v, i, g};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    done    = 1'b0;
    arb_en  = 1'b1;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    arb_en  = 1'b1;
    req     = 16'hFFFF;
    done    = 1'b0;
    #1 reset_n = 1'b0;
    tick();
    tick();
    chk("reset_outs", st(timeout, grant_valid, grant_idx, grant),
        st(0, 0, 4'd0, 16'h0000));
    reset_n = 1'b1;
    tick();
    chk("first_grant", st(timeout, grant_valid, grant_idx, grant),
        st(0, 1, 4'd0, 16'h0001));

    // Rotation between requesters 0 and 15
    do_reset();
    req = 16'h8001;
    tick();
    chk("rot_g0a", st(timeout, grant_valid, grant_idx, grant),
        st(0, 1, 4'd0, 16'h0001));
    done = 1'b1; tick(); done = 1'b0;
    chk("rot_dead1", {31'd0, grant_valid}, 32'd0);
    tick();
    chk("rot_g15a", st(timeout, grant_valid, grant_idx, grant),
        st(0, 1, 4'd15, 16'h8000));
    done = 1'b1; tick(); done = 1'b0;
    chk("rot_dead2", {31'd0, grant_valid}, 32'd0);
    tick();
    chk("rot_g0b", st(timeout, grant_valid, grant_idx, grant),
        st(0, 1, 4'd0, 16'h0001));
    done = 1'b1; tick(); done = 1'b0;
    chk("rot_dead3", {31'd0, grant_valid}, 32'd0);
    tick();
    chk("rot_g15b", st(timeout, grant_valid, grant_idx, grant),
        st(0, 1, 4'd15, 16'h8000));

    // Hold timeout with another requester waiting
    do_reset();
    req = 16'h0006;
    tick();
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("tmo_hold%0d", c),
          st(timeout, grant_valid, grant_idx, grant),
          st(0, 1, 4'd1, 16'h0002));
      if (c < 8) tick();
    end
    tick();
    chk("tmo_pulse", st(timeout, grant_valid, grant_idx, grant),
        st(1, 0, 4'd0, 16'h0000));
    tick();
    chk("tmo_next", st(timeout, grant_valid, grant_idx, grant),
        st(0, 1, 4'd2, 16'h0004));

    // done coinciding with timeout: plain release
    do_reset();
    req = 16'h0006;
    tick();
    for (int c = 1; c < 8; c++) tick();
    chk("tmo_done_pre", st(timeout, grant_valid, grant_idx, grant),
        st(0, 1, 4'd1, 16'h0002));
    done = 1'b1; tick(); done = 1'b0;
    chk("tmo_done_rel", st(timeout, grant_valid, grant_idx, grant),
        st(0, 0, 4'd0, 16'h0000));

    // Sole requester keeps the grant through hold wrap
    do_reset();
    req = 16'h0010;
    tick();
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("sole_%0d", c),
          st(timeout, grant_valid, grant_idx, grant),
          st(0, 1, 4'd4, 16'h0010));
      tick();
    end

    // Owner drops request; arb_en gating
    do_reset();
    req = 16'h0008;
    tick();
    chk("drop_g3", st(timeout, grant_valid, grant_idx, grant),
        st(0, 1, 4'd3, 16'h0008));
    req = 16'h0000;
    arb_en = 1'b0;
    tick();
    chk("drop_rel", st(timeout, grant_valid, grant_idx, grant),
        st(0, 0, 4'd0, 16'h0000));
    req = 16'h0100;
    tick();
    tick();
    chk("arb_off", {31'd0, grant_valid}, 32'd0);
    arb_en = 1'b1;
    tick();
    chk("arb_on_g8", st(timeout, grant_valid, grant_idx, grant),
        st(0, 1, 4'd8, 16'h0100));

    // Async reset mid-grant, pointer back to 0
    do_reset();
    req = 16'h0020;
    tick();
    chk("ares_g5", st(timeout, grant_valid, grant_idx, grant),
        st(0, 1, 4'd5, 16'h0020));
    #2 reset_n = 1'b0;
    #1;
    chk("ares_clear", st(timeout, grant_valid, grant_idx, grant),
        st(0, 0, 4'd0, 16'h0000));
    req = 16'h0060;
    tick();
    reset_n = 1'b1;
    tick();
    chk("ares_ptr0", st(timeout, grant_valid, grant_idx, grant),
        st(0, 1, 4'd5, 16'h0020));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
- Round-robin scheduler that shares one resource among 16 requesters.
- Picks one requester, registers its 4-bit index and drives it through an internal 4-to-16 decoder, producing a one-hot grant bus.
- Holds each grant until the owner releases it or a hold-timeout expires.
- Sits between requester agents and the shared resource they contend for.

Parameters:
- NREQ, 16, number of requesters; fixed at 16 to match the 4-bit index/decoder.
- IDXW, 4, width of grant index.
- MAX_HOLD, 8, maximum consecutive grant cycles before forced rotation when others are waiting (range 1..255).

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- arb_en  input  1  1 = new grants may be issued; 0 = no new grants (a current grant continues until released).
- req  input  16  per-requester request, level-sensitive.
- done  input  1  current owner releases the resource this cycle.
- grant_valid  output  1  a grant is active.
- grant_idx  output  4  index of current owner; 0 when grant_valid=0.
- grant  output  16  one-hot of grant_idx when grant_valid=1, else all 0.
- timeout  output  1  one-cycle pulse on a forced rotation.

Behaviour:
- Reset (async assert, sync release): state=IDLE, ptr=0, hold_cnt=0. Outputs reset to grant_valid=0, grant_idx=0, grant=0, timeout=0.
- States: IDLE, GRANT.
- IDLE:
  - If arb_en=1 and req!=0, pick winner w = first set bit of req scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16 wrap).
  - Next cycle: state=GRANT, grant_idx=w, grant_valid=1, hold_cnt=0, ptr=(w+1) mod 16 (15 -> 0).
  - Latency: req rising in IDLE -> grant at the next clock edge (1 cycle).
- GRANT: release condition rel = done | ~req[grant_idx] | tmo.
  - tmo = (hold_cnt==MAX_HOLD-1) & (req & ~onehot(grant_idx)) != 0.
  - If rel: next state IDLE, grant_valid=0, grant_idx=0, hold_cnt=0. timeout=1 for one cycle only when tmo=1 and done=0 and req[grant_idx]=1. This gives exactly one dead cycle before the next grant.
  - Else if hold_cnt==MAX_HOLD-1 with no other requester: hold_cnt reset to 0, grant retained, no timeout.
  - Else: hold_cnt+1 (saturating width 8).
- done with grant_valid=0 is ignored.
- done and tmo in the same cycle: treated as a normal release, timeout=0.
- arb_en deasserted during GRANT has no effect until release; the FSM then stays in IDLE while arb_en=0.
- Requests are not latched: a req dropped while waiting is simply not considered.
- grant is purely a decode of the registered grant_idx/grant_valid (no extra latency). grant has exactly one bit set iff grant_valid=1.
- reset_n asserted mid-grant: all outputs go to 0 immediately (async), ptr returns to 0.

Decomposition:
- Shared package rr_sched_pkg holds:
  - state enum {IDLE, GRANT};
  - NREQ=16, IDXW=4 constants;
  - typedef req_vec_t (logic [15:0]) and idx_t (logic [3:0]).
- One sub-module: dec4to16 (inputs enable, in[3:0]; output sel[15:0]; all-zero when enable=0), instantiated with enable=grant_valid, in=grant_idx.
- The rotating priority scan is a function in the package.

Test Plan:
- Reset: hold reset_n=0 with req=16'hFFFF -> grant=0, grant_valid=0, timeout=0. Release reset -> next edge grant_idx=0, grant=16'h0001.
- Rotation: req=16'h8001 constant, done pulsed each grant cycle -> grants alternate idx 0, 15, 0, 15, with one dead cycle between each; ptr wraps 15 -> 0.
- Timeout: MAX_HOLD=8, req=16'h0006, owner 1 never asserts done -> after 8 grant cycles timeout pulses once, grant_valid drops 1 cycle, then grant_idx=2, grant=16'h0004.
- Sole requester: req=16'h0010 only, no done for 20 cycles -> grant_idx=4 stays continuously, timeout never asserts.
- Drop/arb_en: owner idx 3 drops req -> release next edge. With arb_en=0 and req=16'h0100 -> no grant. Set arb_en=1 -> grant_idx=8 one cycle later.
- Async reset mid-grant: reset_n=0 between clock edges while grant_idx=5 -> grant=0 immediately. After release, arbitration restarts from ptr=0.
